axi_console_slave: RTL

- Synthesizable AXI write-channel responder for the SoC's memory-mapped console and test-status window at 0x9000_0000.
- Takes CPU BIU writes on the 128-bit bus and returns B responses.
- Pulls one character per console write into a FIFO, which drains as a byte stream toward the UART TX.
- Latches the PASS/FAIL magic words (64'h4_4433_3222 / 64'h23_8234_8720) as sticky status flags for silicon and FPGA runs.

---
 rtl/axi_console_slave.sv | 276 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_console_slave.sv
`default_nettype none
// ============================================================================
// Module   : axi_console_slave
// Purpose  : AXI write-channel responder for the memory-mapped console and
//            test-status window. A console write pushes one character into a
//            byte FIFO that drains toward the UART TX. A status write of a
//            PASS/FAIL magic word sets sticky test flags.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            aw*                 - write address channel (slave side)
//            w*                  - write data channel (slave side)
//            b*                  - write response channel (slave side)
//            tx_valid/ready/data - console byte stream (valid/ready)
//            test_done/test_pass - sticky test status flags
// Revision : 1.0 - initial release
// ============================================================================
module axi_console_slave #(
    parameter int                ADDR_W     = 40,
    parameter int                DATA_W     = 128,
    parameter int                ID_W       = 8,
    parameter int                FIFO_DEPTH = 16,
    parameter logic [ADDR_W-1:0] CON_ADDR   = ADDR_W'(40'h00_9000_0000),
    parameter logic [ADDR_W-1:0] STAT_ADDR  = ADDR_W'(40'h00_9000_0010)
) (
    input  logic                  clk,
    input  logic                  rst,
    // Write address channel
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [ADDR_W-1:0]     awaddr,
    input  logic [3:0]            awlen,
    input  logic [ID_W-1:0]       awid,
    // Write data channel
    input  logic                  wvalid,
    output logic                  wready,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wstrb,
    input  logic                  wlast,
    // Write response channel
    output logic                  bvalid,
    input  logic                  bready,
    output logic [ID_W-1:0]       bid,
    output logic [1:0]            bresp,
    // Console byte stream
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic [7:0]            tx_data,
    // Test status
    output logic                  test_done,
    output logic                  test_pass
);

    localparam int STRB_W = DATA_W / 8;
    localparam int LANE_W = $clog2(STRB_W);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);

    localparam logic [1:0]  c_RESP_OKAY   = 2'b00;
    localparam logic [1:0]  c_RESP_SLVERR = 2'b10;
    localparam logic [1:0]  c_RESP_DECERR = 2'b11;
    localparam logic [63:0] c_MAGIC_PASS  = 64'h0000_0004_4433_3222;
    localparam logic [63:0] c_MAGIC_FAIL  = 64'h0000_0023_8234_8720;
    // Decode ignores the 16-byte offset within a register slot.
    localparam logic [ADDR_W-1:0] c_SLOT_MASK = ~(ADDR_W'(15));

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t            state_q,   state_d;
    logic [ID_W-1:0]   id_q,      id_d;
    logic [3:0]        len_q,     len_d;
    logic [3:0]        beat_q,    beat_d;
    logic              con_q,     con_d;
    logic              stat_q,    stat_d;
    logic              dec_q,     dec_d;
    logic              lenerr_q,  lenerr_d;
    logic              lasterr_q, lasterr_d;
    logic [1:0]        resp_q,    resp_d;
    logic              done_q,    done_d;
    logic              pass_q,    pass_d;

    logic [PTR_W:0]    wptr_q, rptr_q;
    logic [7:0]        mem_q [FIFO_DEPTH];

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic              w_aw_hs;
    logic              w_w_hs;
    logic              w_final_beat;
    logic              w_side_fx;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [PTR_W:0]    w_count;
    logic [LANE_W-1:0] w_lane;
    logic [7:0]        w_byte;
    logic              w_is_con;
    logic              w_is_stat;

    assign w_is_con  = (awaddr & c_SLOT_MASK) == (CON_ADDR  & c_SLOT_MASK);
    assign w_is_stat = (awaddr & c_SLOT_MASK) == (STAT_ADDR & c_SLOT_MASK);

    assign w_count = wptr_q - rptr_q;
    assign w_full  = (w_count == (PTR_W+1)'(FIFO_DEPTH));
    assign w_empty = (w_count == '0);

    assign awready = (state_q == S_IDLE) && !rst;
    // Console target stalls the data channel while the FIFO is full; the
    // full flag comes from the registered count, so a same-cycle pop does
    // not open the gate.
    assign wready  = (state_q == S_DATA) && !(con_q && w_full);
    assign bvalid  = (state_q == S_RESP);
    assign bid     = (state_q == S_RESP) ? id_q   : '0;
    assign bresp   = (state_q == S_RESP) ? resp_q : c_RESP_OKAY;

    assign w_aw_hs      = awvalid && awready;
    assign w_w_hs       = wvalid && wready;
    assign w_final_beat = (beat_q == len_q);
    // Bursts (SLVERR) and undecoded addresses have no side effects.
    assign w_side_fx    = w_w_hs && !dec_q && !lenerr_q;
    assign w_push       = w_side_fx && con_q && (wstrb != '0);
    assign w_pop        = tx_valid && tx_ready;

    // Lowest set strobe selects the byte lane; scan high-to-low so the
    // last match wins.
    always_comb begin
        w_lane = '0;
        for (int k = STRB_W - 1; k >= 0; k--) begin
            if (wstrb[k]) begin
                w_lane = LANE_W'(k);
            end
        end
    end

    assign w_byte = wdata[{w_lane, 3'b000} +: 8];

    // ------------------------------------------------------------------------
    // FSM next-state and status flags
    // ------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        len_d     = len_q;
        beat_d    = beat_q;
        con_d     = con_q;
        stat_d    = stat_q;
        dec_d     = dec_q;
        lenerr_d  = lenerr_q;
        lasterr_d = lasterr_q;
        resp_d    = resp_q;
        done_d    = done_q;
        pass_d    = pass_q;

        case (state_q)
            S_IDLE: begin
                if (w_aw_hs) begin
                    id_d      = awid;
                    len_d     = awlen;
                    beat_d    = '0;
                    con_d     = w_is_con;
                    stat_d    = w_is_stat;
                    dec_d     = !(w_is_con || w_is_stat);
                    lenerr_d  = (awlen != 4'd0);
                    lasterr_d = 1'b0;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (w_w_hs) begin
                    beat_d = beat_q + 4'd1;
                    if (wlast != w_final_beat) begin
                        lasterr_d = 1'b1;
                    end
                    if (w_final_beat) begin
                        state_d = S_RESP;
                        if (dec_q) begin
                            resp_d = c_RESP_DECERR;
                        end else if (lenerr_q || lasterr_q ||
                                     (wlast != w_final_beat)) begin
                            resp_d = c_RESP_SLVERR;
                        end else begin
                            resp_d = c_RESP_OKAY;
                        end
                    end
                end
            end
            S_RESP: begin
                if (bready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Flags freeze once a magic word has landed.
        if (w_side_fx && stat_q && !done_q && (wstrb[7:0] == 8'hFF)) begin
            if (wdata[63:0] == c_MAGIC_PASS) begin
                done_d = 1'b1;
                pass_d = 1'b1;
            end else if (wdata[63:0] == c_MAGIC_FAIL) begin
                done_d = 1'b1;
                pass_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            id_q      <= '0;
            len_q     <= '0;
            beat_q    <= '0;
            con_q     <= 1'b0;
            stat_q    <= 1'b0;
            dec_q     <= 1'b0;
            lenerr_q  <= 1'b0;
            lasterr_q <= 1'b0;
            resp_q    <= c_RESP_OKAY;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            len_q     <= len_d;
            beat_q    <= beat_d;
            con_q     <= con_d;
            stat_q    <= stat_d;
            dec_q     <= dec_d;
            lenerr_q  <= lenerr_d;
            lasterr_q <= lasterr_d;
            resp_q    <= resp_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
        end
    end

    assign test_done = done_q;
    assign test_pass = pass_q;

    // ------------------------------------------------------------------------
    // Console byte FIFO
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (w_push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (w_pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
        end
    end

    // Storage needs no reset; the output is masked while empty.
    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            mem_q[wptr_q[PTR_W-1:0]] <= w_byte;
        end
    end

    assign tx_valid = !w_empty;
    assign tx_data  = w_empty ? 8'h00 : mem_q[rptr_q[PTR_W-1:0]];

endmodule
`default_nettype wire
